// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two result producers, the decode-stage hazard
// probe and the register-file write port. The slave modport is the arbiter
// side; the master modport is the producer / register-file side.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // ALU result path
    logic              alu_valid_i;
    logic              alu_ready_o;
    logic [ADDR_W-1:0] alu_rd_addr_i;
    logic [DATA_W-1:0] alu_rd_data_i;

    // LSU result path
    logic              lsu_valid_i;
    logic              lsu_ready_o;
    logic [ADDR_W-1:0] lsu_rd_addr_i;
    logic [DATA_W-1:0] lsu_rd_data_i;

    // Decode-stage pending-write probe
    logic [ADDR_W-1:0] chk_addr_i;
    logic              chk_pending_o;

    // Register-file write port and occupancy
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              reg_write_en_o;
    logic [CNT_W-1:0]  fifo_count_o;

    modport slave (
        input  alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
        input  lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
        input  chk_addr_i,
        output alu_ready_o, lsu_ready_o, chk_pending_o,
        output rd_addr_o, rd_data_o, reg_write_en_o, fifo_count_o
    );

    modport master (
        output alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
        output lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
        output chk_addr_i,
        input  alu_ready_o, lsu_ready_o, chk_pending_o,
        input  rd_addr_o, rd_data_o, reg_write_en_o, fifo_count_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-side front end. Merges the single-cycle ALU result
// path with the variable-latency LSU path. LSU results wait in a small FIFO;
// the write port is arbitrated ALU-first, with a starvation counter that
// forces the FIFO head through after STARVE_LIMIT consecutive losses, and an
// interlock that holds an ALU write back while an older queued LSU write to
// the same register is still pending.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  LP_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LP_CNT1   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  LP_PTR1   = PTR_W'(1);
    localparam logic [3:0]        LP_STARVE = 4'(STARVE_LIMIT);

    // FIFO storage and control
    logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [DEPTH-1:0]  r_fifo_vld;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [3:0]        r_starve;

    // Registered write port
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_we;

    // Arbitration wires
    logic              w_empty;
    logic              w_full;
    logic              w_alu_match;
    logic              w_chk_match;
    logic              w_conflict;
    logic              w_fifo_win;
    logic              w_alu_win;
    logic              w_enq;
    logic              w_deq;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == LP_FULL);
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Address match of the ALU destination and of the probe against every live FIFO entry
    always_comb begin
        w_alu_match = 1'b0;
        w_chk_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_fifo_vld[i] && (r_fifo_addr[i] == bus.alu_rd_addr_i)) begin
                w_alu_match = 1'b1;
            end
            if (r_fifo_vld[i] && (r_fifo_addr[i] == bus.chk_addr_i)) begin
                w_chk_match = 1'b1;
            end
        end
    end

    // An ALU write to a register that still has an older LSU write queued
    // must wait, otherwise the older value would land last. x0 is exempt
    // since writes to it are discarded anyway.
    assign w_conflict = bus.alu_valid_i && (bus.alu_rd_addr_i != '0) && w_alu_match;

    // FIFO wins when the ALU is idle, blocked by the interlock, or the FIFO
    // has been starved long enough; otherwise the ALU has priority.
    assign w_fifo_win = !rst && !w_empty &&
                        (!bus.alu_valid_i || w_conflict || (r_starve == LP_STARVE));
    assign w_alu_win  = !rst && bus.alu_valid_i && !w_fifo_win;

    assign w_deq = w_fifo_win;
    assign w_enq = bus.lsu_valid_i && bus.lsu_ready_o;

    // A slot freed by a same-cycle dequeue is not offered back until next cycle
    assign bus.lsu_ready_o   = !rst && !w_full;
    assign bus.alu_ready_o   = w_alu_win;
    assign bus.fifo_count_o  = r_count;
    assign bus.rd_addr_o     = r_rd_addr;
    assign bus.rd_data_o     = r_rd_data;
    assign bus.reg_write_en_o = r_we;
    assign bus.chk_pending_o = (bus.chk_addr_i != '0) &&
                               (w_chk_match || (r_we && (r_rd_addr == bus.chk_addr_i)));

    // FIFO payload storage; contents are meaningless unless the slot's valid bit is set
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_addr[r_wr_ptr] <= bus.lsu_rd_addr_i;
            r_fifo_data[r_wr_ptr] <= bus.lsu_rd_data_i;
        end
    end

    // FIFO pointers, per-slot valid bits and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fifo_vld <= '0;
        end else begin
            // Enqueue only happens when not full and dequeue only when not
            // empty, so the two pointers never name the same slot here.
            if (w_enq) begin
                r_fifo_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr             <= r_wr_ptr + LP_PTR1;
            end
            if (w_deq) begin
                r_fifo_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr             <= r_rd_ptr + LP_PTR1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + LP_CNT1;
                2'b01:   r_count <= r_count - LP_CNT1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Count consecutive arbitration losses of a non-empty FIFO, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst || w_empty || w_deq) begin
            r_starve <= '0;
        end else if (w_alu_win && (r_starve != LP_STARVE)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Register the winner onto the write port; x0 updates address/data but never enables
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_we      <= 1'b0;
        end else if (w_alu_win) begin
            r_rd_addr <= bus.alu_rd_addr_i;
            r_rd_data <= bus.alu_rd_data_i;
            r_we      <= (bus.alu_rd_addr_i != '0);
        end else if (w_fifo_win) begin
            r_rd_addr <= w_head_addr;
            r_rd_data <= w_head_data;
            r_we      <= (w_head_addr != '0);
        end else begin
            r_we      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter. Each table row is one
// clock cycle: the inputs driven during that cycle, the combinational outputs
// expected for those inputs, and the registered outputs expected to be
// visible during that cycle.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) bus ();

    regfile_wb_arbiter #(
        .DATA_W(32), .ADDR_W(5), .DEPTH(4), .STARVE_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  ca;
        logic        ear;
        logic        elr;
        logic        ecp;
        logic        ewe;
        logic [4:0]  era;
        logic [31:0] erd;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    function automatic vec_t mk(
        input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic lv, input logic [4:0] la, input logic [31:0] ld, input logic [4:0] ca,
        input logic ear, input logic elr, input logic ecp, input logic ewe,
        input logic [4:0] era, input logic [31:0] erd, input logic [2:0] ecnt);
        vec_t v;
        v.rst = r;   v.av = av;   v.aa = aa;   v.ad = ad;
        v.lv = lv;   v.la = la;   v.ld = ld;   v.ca = ca;
        v.ear = ear; v.elr = elr; v.ecp = ecp; v.ewe = ewe;
        v.era = era; v.erd = erd; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst               = v.rst;
        bus.alu_valid_i   = v.av;
        bus.alu_rd_addr_i = v.aa;
        bus.alu_rd_data_i = v.ad;
        bus.lsu_valid_i   = v.lv;
        bus.lsu_rd_addr_i = v.la;
        bus.lsu_rd_data_i = v.ld;
        bus.chk_addr_i    = v.ca;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_cmp = 0;
        n_bad = 0;

        //          rst av aa  ad            lv la  ld     ca | ar lr cp we ra  rd            cnt
        vecs.push_back(mk(1, 1, 5, 32'hDEADBEEF, 1, 3, 32'h33, 0,  0, 0, 0, 0, 0, 32'h0,        0)); // 0 reset gating
        // single ALU write
        vecs.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  0,  1, 1, 0, 0, 0, 32'h0,        0)); // 1
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  5,  0, 1, 1, 1, 5, 32'hDEADBEEF, 0)); // 2
        // two back-to-back LSU writes, ALU idle
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 7, 32'h11, 0,  0, 1, 0, 0, 5, 32'hDEADBEEF, 0)); // 3
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 8, 32'h22, 7,  0, 1, 1, 0, 5, 32'hDEADBEEF, 1)); // 4
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  8,  0, 1, 1, 1, 7, 32'h11,       1)); // 5
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  7,  0, 1, 0, 1, 8, 32'h22,       0)); // 6
        // starvation guard: ALU streams to x1, one LSU entry to x9
        vecs.push_back(mk(0, 1, 1, 32'hA0,       1, 9, 32'h99, 0,  1, 1, 0, 0, 8, 32'h22,       0)); // 7
        vecs.push_back(mk(0, 1, 1, 32'hA1,       0, 0, 32'h0,  9,  1, 1, 1, 1, 1, 32'hA0,       1)); // 8
        vecs.push_back(mk(0, 1, 1, 32'hA2,       0, 0, 32'h0,  0,  1, 1, 0, 1, 1, 32'hA1,       1)); // 9
        vecs.push_back(mk(0, 1, 1, 32'hA3,       0, 0, 32'h0,  0,  1, 1, 0, 1, 1, 32'hA2,       1)); // 10
        vecs.push_back(mk(0, 1, 1, 32'hA4,       0, 0, 32'h0,  0,  0, 1, 0, 1, 1, 32'hA3,       1)); // 11 forced FIFO
        vecs.push_back(mk(0, 1, 1, 32'hA4,       0, 0, 32'h0,  0,  1, 1, 0, 1, 9, 32'h99,       0)); // 12
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 1, 0, 1, 1, 32'hA4,       0)); // 13
        // write-after-write interlock on x4
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 4, 32'h44, 0,  0, 1, 0, 0, 1, 32'hA4,       0)); // 14
        vecs.push_back(mk(0, 1, 4, 32'h4A,       0, 0, 32'h0,  4,  0, 1, 1, 0, 1, 32'hA4,       1)); // 15
        vecs.push_back(mk(0, 1, 4, 32'h4A,       0, 0, 32'h0,  4,  1, 1, 1, 1, 4, 32'h44,       0)); // 16
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  4,  0, 1, 1, 1, 4, 32'h4A,       0)); // 17
        // fill the FIFO while the ALU saturates the port
        vecs.push_back(mk(0, 1, 2, 32'hC0,       1, 10, 32'hB0, 0, 1, 1, 0, 0, 4, 32'h4A,       0)); // 18
        vecs.push_back(mk(0, 1, 2, 32'hC1,       1, 11, 32'hB1, 0, 1, 1, 0, 1, 2, 32'hC0,       1)); // 19
        vecs.push_back(mk(0, 1, 2, 32'hC2,       1, 12, 32'hB2, 0, 1, 1, 0, 1, 2, 32'hC1,       2)); // 20
        vecs.push_back(mk(0, 1, 2, 32'hC3,       1, 13, 32'hB3, 0, 1, 1, 0, 1, 2, 32'hC2,       3)); // 21
        vecs.push_back(mk(0, 1, 2, 32'hC4,       1, 14, 32'hB4, 0, 0, 0, 0, 1, 2, 32'hC3,       4)); // 22 full
        vecs.push_back(mk(0, 1, 2, 32'hC4,       0, 0, 32'h0,  0,  1, 1, 0, 1, 10, 32'hB0,      3)); // 23
        // ALU write to x0, then drain, then LSU write to x0
        vecs.push_back(mk(0, 1, 0, 32'hD0,       0, 0, 32'h0,  0,  1, 1, 0, 1, 2, 32'hC4,       3)); // 24
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 1, 0, 0, 0, 32'hD0,       3)); // 25
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 1, 0, 1, 11, 32'hB1,      2)); // 26
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 1, 0, 1, 12, 32'hB2,      1)); // 27
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'hE0, 0,  0, 1, 0, 1, 13, 32'hB3,      0)); // 28
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 1, 0, 0, 13, 32'hB3,      1)); // 29
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 1, 0, 0, 0, 32'hE0,       0)); // 30
        // reset with three entries queued
        vecs.push_back(mk(0, 1, 3, 32'h30,       1, 20, 32'hF0, 0, 1, 1, 0, 0, 0, 32'hE0,       0)); // 31
        vecs.push_back(mk(0, 1, 3, 32'h31,       1, 21, 32'hF1, 0, 1, 1, 0, 1, 3, 32'h30,       1)); // 32
        vecs.push_back(mk(0, 1, 3, 32'h32,       1, 22, 32'hF2, 21, 1, 1, 1, 1, 3, 32'h31,      2)); // 33
        vecs.push_back(mk(1, 1, 3, 32'h33,       1, 23, 32'hF3, 22, 0, 0, 1, 1, 3, 32'h32,      3)); // 34
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  22, 0, 1, 0, 0, 0, 32'h0,       0)); // 35
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 1, 0, 0, 0, 32'h0,        0)); // 36
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  0,  0, 1, 0, 0, 0, 32'h0,        0)); // 37

        // Initial reset: hold for two edges, then sit 1 time unit after an edge
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #2;
            check("alu_ready",     i, 32'(bus.alu_ready_o),    32'(vecs[i].ear));
            check("lsu_ready",     i, 32'(bus.lsu_ready_o),    32'(vecs[i].elr));
            check("chk_pending",   i, 32'(bus.chk_pending_o),  32'(vecs[i].ecp));
            check("reg_write_en",  i, 32'(bus.reg_write_en_o), 32'(vecs[i].ewe));
            check("rd_addr",       i, 32'(bus.rd_addr_o),      32'(vecs[i].era));
            check("rd_data",       i, bus.rd_data_o,           vecs[i].erd);
            check("fifo_count",    i, 32'(bus.fifo_count_o),   32'(vecs[i].ecnt));
            @(posedge clk);
            #1;
        end

        // Minimum LSU latency: handshake cycle to write-enable visible is two cycles
        drive(mk(0, 0, 0, 0, 1, 25, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check("lat_lsu_ready", 100, 32'(bus.lsu_ready_o), 32'd1);
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc = 1;
        while (!bus.reg_write_en_o && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("lat_cycles", 101, 32'(cyc), 32'd2);
        check("lat_rd_addr", 102, 32'(bus.rd_addr_o), 32'd25);
        check("lat_rd_data", 103, bus.rd_data_o, 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
